fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have port: CLK  input  1  pipeline clock; all state changes on rising edge.
REQ-003 SHALL have port: RST  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: ihit  input  1  instruction memory returned iload for imemaddr this cycle.
REQ-005 SHALL have port: iload  input  32  instruction word from instruction memory.
REQ-006 SHALL have ports: imemREN  output  1  fetch request; imemaddr  output  32  fetch address (= PC).
REQ-007 SHALL have ports: pc_en, flushed1, id_en1  input  1 each  hazard-unit PC enable, IF/ID flush, IF/ID enable.
REQ-008 SHALL have ports: pc_src  input  2  {0 NEXT, 1 JUMP, 2 JR, 3 BRANCH}; branch_sel  input  1  branch taken.
REQ-009 SHALL have ports: id_jaddr  input  26  J-type target field; id_imm  input  16  branch offset; id_jr_addr  input  32  register target.
REQ-010 SHALL have ports: mem_stall  input  1  downstream freeze; halt  input  1  halt retired.
REQ-011 SHALL have ports: id_instr  output  32, id_npc  output  32, id_valid  output  1  IF/ID latch contents.

Function
REQ-012 SHALL define fire = (ihit | held) & !mem_stall & state==RUN; PC and IF/ID change only on fire (except reset).
REQ-013 SHALL drive imemaddr = PC combinationally; imemREN = (state==RUN) & !held.
REQ-014 SHALL compute next PC on fire when pc_en=1: NEXT -> PC+4; JUMP -> {id_npc[31:28], id_jaddr, 2'b00}; JR -> id_jr_addr; BRANCH -> branch_sel ? id_npc + (sign-extended id_imm << 2) : PC+4; all adds mod 2^32.
REQ-015 SHALL hold PC on fire when pc_en=0.
REQ-016 SHALL, on fire with id_en1=1: if flushed1 load id_instr=0, id_valid=0, id_npc=0; else load id_instr = held ? buf : iload, id_npc = PC+4, id_valid=1.
REQ-017 SHALL hold IF/ID on fire with id_en1=0, and on every non-fire cycle.
REQ-018 SHALL implement a one-entry skid buffer: ihit & mem_stall & !held & state==RUN -> buf<=iload, held<=1.
REQ-019 SHALL clear held on fire; buf contents then don't-care.
REQ-020 SHALL ignore ihit while held=1 (imemREN is 0).
REQ-021 SHALL implement states RUN, HALTED: RUN -> HALTED when halt=1 (priority over fire that cycle, no PC/IF-ID update); HALTED sticky until RST.
REQ-022 SHALL in HALTED drive imemREN=0, hold PC, and load IF/ID with bubble (id_valid=0) on the transition cycle.
REQ-023 SHALL give flushed1 and pc_src redirect effect only on fire; redirects are never latched for later cycles.

Reset
REQ-024 SHALL on RST=1 at a rising edge set PC=RESET_PC, id_instr=0, id_npc=0, id_valid=0, held=0, state=RUN, overriding all other inputs.
REQ-025 SHALL drive imemREN=1, imemaddr=RESET_PC in the first cycle after reset release.

Verification
REQ-026 SHALL test sequential fetch: ihit=1 three cycles, pc_src=NEXT -> imemaddr 0,4,8,C; id_npc 4,8,C; id_valid=1.
REQ-027 SHALL test taken branch: id_npc=0x20, id_imm=16'hFFFE, pc_src=BRANCH, branch_sel=1, flushed1=1, ihit=1 -> PC=0x18, id_valid=0.
REQ-028 SHALL test jump: id_npc=0x40000010, id_jaddr=26'h0000100, pc_src=JUMP -> PC=0x40000400.
REQ-029 SHALL test skid: ihit=1, mem_stall=1, iload=0x8C220004 -> held=1, imemREN=0, IF/ID unchanged; mem_stall=0, ihit=0 -> id_instr=0x8C220004, PC+=4, imemREN=1.
REQ-030 SHALL test load-use: pc_en=0, ihit=1, PC=0x10 -> PC stays 0x10, id_instr=iload, id_npc=0x14.
REQ-031 SHALL test halt and reset: halt=1 with ihit=1 -> imemREN=0, PC frozen, id_valid=0; RST=1 -> PC=RESET_PC, state RUN.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch pipeline stage with PC update, IF/ID latch,
// a one-entry skid buffer for back-pressure, and a sticky halt state.
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   ihit, iload         instruction memory response for imemaddr this cycle
//   imemREN, imemaddr   fetch request and address (address is the PC)
//   pc_en               hazard-unit PC enable
//   flushed1, id_en1    IF/ID flush and IF/ID enable
//   pc_src, branch_sel  next-PC select {NEXT, JUMP, JR, BRANCH}, branch taken
//   id_jaddr, id_imm    J-type target field, branch offset
//   id_jr_addr          register jump target
//   mem_stall, halt     downstream freeze, halt retired
//   id_instr, id_npc,   IF/ID latch contents
//   id_valid
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        pc_en,
  input  logic        flushed1,
  input  logic        id_en1,
  input  logic [1:0]  pc_src,
  input  logic        branch_sel,
  input  logic [25:0] id_jaddr,
  input  logic [15:0] id_imm,
  input  logic [31:0] id_jr_addr,
  input  logic        mem_stall,
  input  logic        halt,
  output logic [31:0] id_instr,
  output logic [31:0] id_npc,
  output logic        id_valid
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  localparam logic [1:0] PC_NEXT   = 2'd0;
  localparam logic [1:0] PC_JUMP   = 2'd1;
  localparam logic [1:0] PC_JR     = 2'd2;
  localparam logic [1:0] PC_BRANCH = 2'd3;

  logic [0:0]  state_q;
  logic [31:0] pc_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_npc_q;
  logic        id_valid_q;
  logic        held_q;
  logic [31:0] skid_q;

  logic        run;
  logic        fire;
  logic        skid_load;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] pc_next;

  assign run       = (state_q == RUN);
  // halt wins over fire in the cycle it arrives
  assign fire      = (ihit | held_q) & ~mem_stall & run & ~halt;
  // capture a returning word that cannot be consumed because of the stall
  assign skid_load = ihit & mem_stall & ~held_q & run & ~halt;
  assign pc_plus4  = pc_q + 32'd4;
  assign br_off    = {{14{id_imm[15]}}, id_imm, 2'b00};

  always_comb begin
    pc_next = pc_plus4;
    unique case (pc_src)
      PC_NEXT:   pc_next = pc_plus4;
      PC_JUMP:   pc_next = {id_npc_q[31:28], id_jaddr, 2'b00};
      PC_JR:     pc_next = id_jr_addr;
      PC_BRANCH: pc_next = branch_sel ? (id_npc_q + br_off) : pc_plus4;
      default:   pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      id_instr_q <= 32'd0;
      id_npc_q   <= 32'd0;
      id_valid_q <= 1'b0;
      held_q     <= 1'b0;
      skid_q     <= 32'd0;
    end else if (run && halt) begin
      // enter halt with a bubble in IF/ID; PC frozen from here on
      state_q    <= HALTED;
      id_instr_q <= 32'd0;
      id_npc_q   <= 32'd0;
      id_valid_q <= 1'b0;
      held_q     <= 1'b0;
    end else if (fire) begin
      if (pc_en) begin
        pc_q <= pc_next;
      end
      if (id_en1) begin
        if (flushed1) begin
          id_instr_q <= 32'd0;
          id_npc_q   <= 32'd0;
          id_valid_q <= 1'b0;
        end else begin
          id_instr_q <= held_q ? skid_q : iload;
          id_npc_q   <= pc_plus4;
          id_valid_q <= 1'b1;
        end
      end
      held_q <= 1'b0;
    end else if (skid_load) begin
      skid_q <= iload;
      held_q <= 1'b1;
    end
  end

  assign imemaddr = pc_q;
  assign imemREN  = run & ~held_q;
  assign id_instr = id_instr_q;
  assign id_npc   = id_npc_q;
  assign id_valid = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit;
  logic [31:0] iload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        pc_en;
  logic        flushed1;
  logic        id_en1;
  logic [1:0]  pc_src;
  logic        branch_sel;
  logic [25:0] id_jaddr;
  logic [15:0] id_imm;
  logic [31:0] id_jr_addr;
  logic        mem_stall;
  logic        halt;
  logic [31:0] id_instr;
  logic [31:0] id_npc;
  logic        id_valid;

  fetch_stage #(.RESET_PC(32'h00000000)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ihit       (ihit),
    .iload      (iload),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .pc_en      (pc_en),
    .flushed1   (flushed1),
    .id_en1     (id_en1),
    .pc_src     (pc_src),
    .branch_sel (branch_sel),
    .id_jaddr   (id_jaddr),
    .id_imm     (id_imm),
    .id_jr_addr (id_jr_addr),
    .mem_stall  (mem_stall),
    .halt       (halt),
    .id_instr   (id_instr),
    .id_npc     (id_npc),
    .id_valid   (id_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic        ren;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    driver_done = 1'b0;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%08h required=%08h", nm, fld, act, req);
    end
  endtask

  // Monitor: after every edge, compare the state the DUT presents against the
  // expectation queued for that edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        cmp(nm, "imemaddr", imemaddr, e.pc);
        cmp(nm, "imemREN", {31'd0, imemREN}, {31'd0, e.ren});
        cmp(nm, "id_instr", id_instr, e.instr);
        cmp(nm, "id_npc", id_npc, e.npc);
        cmp(nm, "id_valid", {31'd0, id_valid}, {31'd0, e.valid});
      end
    end
  end

  // Queue the expected post-edge state, then let one edge pass.
  task automatic cyc(input string nm, input logic [31:0] pc, input logic ren,
                     input logic [31:0] instr, input logic [31:0] npc, input logic valid);
    exp_t e;
    e.pc = pc; e.ren = ren; e.instr = instr; e.npc = npc; e.valid = valid;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; iload = 32'd0; pc_en = 1'b1; flushed1 = 1'b0;
    id_en1 = 1'b1; pc_src = 2'd0; branch_sel = 1'b0; id_jaddr = 26'd0;
    id_imm = 16'd0; id_jr_addr = 32'd0; mem_stall = 1'b0; halt = 1'b0;
    #2;
    ihit = 1'b1; iload = 32'hFFFF_FFFF;
    cyc("reset0", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    cyc("reset1", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    RST = 1'b0;

    // sequential fetch
    iload = 32'h1111_1111; cyc("seq0", 32'h4, 1'b1, 32'h1111_1111, 32'h4, 1'b1);
    iload = 32'h2222_2222; cyc("seq1", 32'h8, 1'b1, 32'h2222_2222, 32'h8, 1'b1);
    iload = 32'h3333_3333; cyc("seq2", 32'hC, 1'b1, 32'h3333_3333, 32'hC, 1'b1);

    // JR then NEXT to place id_npc at 0x20
    pc_src = 2'd2; id_jr_addr = 32'h1C; iload = 32'h4444_4444;
    cyc("jr1c", 32'h1C, 1'b1, 32'h4444_4444, 32'h10, 1'b1);
    pc_src = 2'd0; iload = 32'h5555_5555;
    cyc("next20", 32'h20, 1'b1, 32'h5555_5555, 32'h20, 1'b1);

    // taken branch with flush: 0x20 + (-2 << 2) = 0x18
    pc_src = 2'd3; branch_sel = 1'b1; id_imm = 16'hFFFE; flushed1 = 1'b1;
    iload = 32'h6666_6666;
    cyc("br_taken", 32'h18, 1'b1, 32'h0, 32'h0, 1'b0);
    branch_sel = 1'b0; flushed1 = 1'b0; iload = 32'h7777_7777;
    cyc("br_not", 32'h1C, 1'b1, 32'h7777_7777, 32'h1C, 1'b1);

    // jump with id_npc = 0x40000010
    pc_src = 2'd2; id_jr_addr = 32'h4000_000C; iload = 32'h8888_8888;
    cyc("jr4000", 32'h4000_000C, 1'b1, 32'h8888_8888, 32'h20, 1'b1);
    pc_src = 2'd0; iload = 32'h9999_9999;
    cyc("next4010", 32'h4000_0010, 1'b1, 32'h9999_9999, 32'h4000_0010, 1'b1);
    pc_src = 2'd1; id_jaddr = 26'h0000100; iload = 32'hAAAA_AAAA;
    cyc("jump", 32'h4000_0400, 1'b1, 32'hAAAA_AAAA, 32'h4000_0014, 1'b1);

    // no ihit: nothing moves
    pc_src = 2'd0; ihit = 1'b0; iload = 32'hBBBB_BBBB;
    cyc("idle", 32'h4000_0400, 1'b1, 32'hAAAA_AAAA, 32'h4000_0014, 1'b1);

    // skid buffer
    ihit = 1'b1; mem_stall = 1'b1; iload = 32'h8C22_0004;
    cyc("skid_cap", 32'h4000_0400, 1'b0, 32'hAAAA_AAAA, 32'h4000_0014, 1'b1);
    iload = 32'hCCCC_CCCC;
    cyc("skid_hold", 32'h4000_0400, 1'b0, 32'hAAAA_AAAA, 32'h4000_0014, 1'b1);
    mem_stall = 1'b0; ihit = 1'b0; iload = 32'hDEAD_BEEF;
    cyc("skid_rel", 32'h4000_0404, 1'b1, 32'h8C22_0004, 32'h4000_0404, 1'b1);

    // stall with no pending word holds everything
    mem_stall = 1'b1;
    cyc("stall_idle", 32'h4000_0404, 1'b1, 32'h8C22_0004, 32'h4000_0404, 1'b1);
    mem_stall = 1'b0;

    // IF/ID enable low: PC moves, latch holds
    ihit = 1'b1; id_en1 = 1'b0; iload = 32'hEEEE_EEEE;
    cyc("id_en0", 32'h4000_0408, 1'b1, 32'h8C22_0004, 32'h4000_0404, 1'b1);
    id_en1 = 1'b1;

    // load-use at PC = 0x10
    pc_src = 2'd2; id_jr_addr = 32'h10; iload = 32'h1234_5678;
    cyc("jr10", 32'h10, 1'b1, 32'h1234_5678, 32'h4000_040C, 1'b1);
    pc_src = 2'd0; pc_en = 1'b0; iload = 32'h0000_0055;
    cyc("load_use", 32'h10, 1'b1, 32'h0000_0055, 32'h14, 1'b1);
    pc_en = 1'b1;

    // halt wins over fire; sticky afterwards even with a redirect present
    halt = 1'b1; iload = 32'h0BAD_0BAD;
    cyc("halt", 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);
    halt = 1'b0; pc_src = 2'd2; id_jr_addr = 32'h100;
    cyc("halted", 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);

    // reset out of halt
    pc_src = 2'd0; RST = 1'b1;
    cyc("rst_halt", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    RST = 1'b0; iload = 32'h0F0F_0F0F;
    cyc("post_rst", 32'h4, 1'b1, 32'h0F0F_0F0F, 32'h4, 1'b1);

    ihit = 1'b0;
    repeat (5) begin
      if (exp_q.size() != 0) @(posedge CLK);
    end
    #3;
    driver_done = 1'b1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    if (!driver_done) begin
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
    end
  end

endmodule
